// File: rtl/io_pins_pkg.sv
// Shared sizing and types for the I/O pin snapshot register.
// Other blocks import this package so they can consume the stored image by type.
package io_pins_pkg;

    localparam int N_PINS  = 132;
    localparam int BYTE_W  = 8;
    localparam int N_BYTES = (N_PINS + BYTE_W - 1) / BYTE_W;
    localparam int CNT_W   = 16;

    typedef logic [BYTE_W-1:0] pin_mem_t [0:N_BYTES-1];

endpackage

// File: rtl/io_pins_byte_reg.sv
// One entry of the pin image: loads a byte on request and flags whether
// the load altered the stored value.
module io_pins_byte_reg
    import io_pins_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] q,
    output logic              changed
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            changed <= 1'b0;
        end else if (load) begin
            changed <= (d != q);
            q       <= d;
        end
    end

endmodule

// File: rtl/io_pins_fpga.sv
// Snapshot register for the general-purpose I/O pins: whole-vector capture
// into byte entries, with per-entry change flags and a capture counter.
module io_pins_fpga
    import io_pins_pkg::*;
(
    input  logic               CLK50,
    input  logic               rst_n,
    input  logic               write_enable,
    input  logic [N_PINS-1:0]  io_pins,
    output pin_mem_t           memory_pin_state,
    output logic               capture_done,
    output logic [N_BYTES-1:0] changed_mask,
    output logic [CNT_W-1:0]   capture_count
);

    localparam int PAD_W = N_BYTES * BYTE_W - N_PINS;

    // The top entry's unused bits are tied to zero here so they can never hold anything else.
    logic [N_BYTES*BYTE_W-1:0] pins_padded;
    assign pins_padded = {{PAD_W{1'b0}}, io_pins};

    for (genvar k = 0; k < N_BYTES; k++) begin : g_entry
        io_pins_byte_reg u_entry (
            .clk     (CLK50),
            .rst_n   (rst_n),
            .load    (write_enable),
            .d       (pins_padded[k*BYTE_W +: BYTE_W]),
            .q       (memory_pin_state[k]),
            .changed (changed_mask[k])
        );
    end

    always_ff @(posedge CLK50) begin
        if (!rst_n) begin
            capture_done  <= 1'b0;
            capture_count <= '0;
        end else begin
            capture_done <= write_enable;
            if (write_enable) begin
                capture_count <= capture_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_pins_fpga.sv
// Randomized scoreboard bench for io_pins_fpga: a byte-image reference model
// queues expected results per capture and a monitor checks them on capture_done.
module tb_io_pins_fpga;
    import io_pins_pkg::*;

    typedef struct {
        logic [135:0] img;
        logic [16:0]  mask;
        logic [15:0]  count;
    } exp_t;

    logic               CLK50;
    logic               rst_n;
    logic               write_enable;
    logic [N_PINS-1:0]  io_pins;
    pin_mem_t           memory_pin_state;
    logic               capture_done;
    logic [N_BYTES-1:0] changed_mask;
    logic [CNT_W-1:0]   capture_count;

    io_pins_fpga dut (
        .CLK50            (CLK50),
        .rst_n            (rst_n),
        .write_enable     (write_enable),
        .io_pins          (io_pins),
        .memory_pin_state (memory_pin_state),
        .capture_done     (capture_done),
        .changed_mask     (changed_mask),
        .capture_count    (capture_count)
    );

    initial CLK50 = 1'b0;
    always #10 CLK50 = ~CLK50;

    exp_t         exp_q[$];
    logic [135:0] model_img;
    logic [16:0]  model_mask;
    logic [15:0]  model_count;
    logic         model_done;
    int           n_checks;
    int           n_fail;

    function automatic logic [135:0] dut_image();
        logic [135:0] v;
        for (int k = 0; k < N_BYTES; k++) v[k*8 +: 8] = memory_pin_state[k];
        return v;
    endfunction

    function automatic logic [135:0] all_ones_pins();
        logic [135:0] v;
        v = '0;
        v[131:0] = '1;
        return v;
    endfunction

    task automatic compare(input string name, input logic [135:0] act, input logic [135:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: the model applies the behavioural rules to the inputs held across the edge.
    task automatic apply_stimulus(input logic rst_v, input logic we_v, input logic [131:0] pins_v);
        logic [135:0] new_img;
        rst_n        = rst_v;
        write_enable = we_v;
        io_pins      = pins_v;
        @(posedge CLK50);
        if (!rst_v) begin
            model_img   = '0;
            model_mask  = '0;
            model_count = '0;
            model_done  = 1'b0;
        end else begin
            model_done = we_v;
            if (we_v) begin
                new_img = {4'b0, pins_v};
                for (int k = 0; k < N_BYTES; k++)
                    model_mask[k] = (new_img[k*8 +: 8] != model_img[k*8 +: 8]);
                model_img   = new_img;
                model_count = model_count + 16'd1;
                exp_q.push_back('{img: model_img, mask: model_mask, count: model_count});
            end
        end
        #1;
    endtask

    task automatic check_output(input string tag);
        compare({tag, ".image"}, dut_image(), model_img);
        compare({tag, ".mask"}, 136'(changed_mask), 136'(model_mask));
        compare({tag, ".count"}, 136'(capture_count), 136'(model_count));
        compare({tag, ".done"}, 136'(capture_done), 136'(model_done));
    endtask

    // Monitor: checks the done strobe every cycle and scores each presented capture.
    always @(negedge CLK50) begin
        exp_t e;
        if (rst_n !== 1'bx) begin
            compare("mon.done", 136'(capture_done), 136'(model_done));
            if (capture_done === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL mon.unexpected: actual capture_done 1 required no pending capture");
                end else begin
                    e = exp_q.pop_front();
                    compare("mon.image", dut_image(), e.img);
                    compare("mon.mask", 136'(changed_mask), 136'(e.mask));
                    compare("mon.count", 136'(capture_count), 136'(e.count));
                end
            end
        end
    end

    initial begin
        logic [131:0] scen_a;
        logic [131:0] ones;
        logic [135:0] req_a;
        logic [131:0] rnd;
        n_checks    = 0;
        n_fail      = 0;
        model_img   = '0;
        model_mask  = '0;
        model_count = '0;
        model_done  = 1'b0;
        ones   = '1;
        scen_a = 132'h123456789ABCDEF;
        req_a  = 136'h0;
        req_a[63:0] = 64'h0123456789ABCDEF;

        apply_stimulus(1'b0, 1'b1, ones);
        apply_stimulus(1'b0, 1'b1, ones);
        check_output("reset");
        compare("reset.const_image", dut_image(), 136'h0);

        apply_stimulus(1'b1, 1'b1, scen_a);
        check_output("scen_a");
        compare("scen_a.const_image", dut_image(), req_a);
        compare("scen_a.const_mask", 136'(changed_mask), 136'h000FF);
        compare("scen_a.const_count", 136'(capture_count), 136'd1);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, ones);
            check_output("hold");
        end
        compare("hold.const_image", dut_image(), req_a);

        apply_stimulus(1'b1, 1'b1, ones);
        check_output("full");
        compare("full.const_image", dut_image(), all_ones_pins());
        compare("full.const_entry16", 136'(memory_pin_state[16]), 136'h0F);
        compare("full.const_mask", 136'(changed_mask), 136'h1FFFF);
        compare("full.const_count", 136'(capture_count), 136'd2);

        apply_stimulus(1'b1, 1'b1, ones);
        check_output("repeat");
        compare("repeat.const_mask", 136'(changed_mask), 136'h0);

        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            apply_stimulus(1'b1, 1'b1, rnd ^ 132'(i + 1));
            check_output("b2b");
        end
        compare("b2b.const_count", 136'(capture_count), 136'd6);

        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(3) == 0) rnd[63:0] = model_img[63:0];
            apply_stimulus($urandom_range(31) != 0, $urandom_range(1) == 1, rnd);
            check_output("rand");
        end

        apply_stimulus(1'b1, 1'b1, scen_a);
        apply_stimulus(1'b0, 1'b1, ones);
        check_output("rst_prio");
        compare("rst_prio.const_image", dut_image(), 136'h0);
        compare("rst_prio.const_count", 136'(capture_count), 136'd0);

        apply_stimulus(1'b1, 1'b0, ones);
        apply_stimulus(1'b1, 1'b0, ones);
        compare("drain.pending", 136'(exp_q.size()), 136'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
